drom_arbiter: RTL and testbench

Two-port read arbiter and burst sequencer for the shared 128 x 16 data ROM (DROM). It sits between the ROM and two requesters: port A for the data/load path and port B for the fetch path. It grants one requester at a time and drives the ROM address, including auto-incremented burst beats. It returns each ROM word to the owning port with a valid strobe and holds it afterwards.

---
 rtl/drom_pkg.sv | 28 ++
 rtl/drom_arb_pick.sv | 25 ++
 rtl/drom_arbiter.sv | 144 ++++++++++++++
 tb/tb_drom_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/drom_pkg.sv
// Shared types and constants for the DROM two-port read arbiter.
package drom_pkg;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 16;
  localparam int BURST_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  typedef struct packed {
    logic  valid;
    port_t port;
    logic  last;
  } slot_t;

  function automatic port_t other_port(input port_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/drom_arb_pick.sv
// Winner selection between ports A and B.
// DROM_ARB_RR_EN selects round-robin (pointer port wins ties); otherwise A has fixed priority.
module drom_arb_pick
  import drom_pkg::*;
(
  input  logic  a_req,
  input  logic  b_req,
`ifdef DROM_ARB_RR_EN
  input  port_t ptr,
`endif
  output logic  any_req,
  output port_t winner
);

  always_comb begin
    any_req = a_req | b_req;
    winner  = PORT_A;
`ifdef DROM_ARB_RR_EN
    if (b_req && (!a_req || ptr == PORT_B)) winner = PORT_B;
`else
    if (b_req && !a_req) winner = PORT_B;
`endif
  end

endmodule

// File: rtl/drom_arbiter.sv
// Two-port read arbiter and burst sequencer for the shared 128 x 16 DROM.
// Define DROM_ARB_RR_EN for round-robin arbitration; the default build uses fixed A-over-B priority.
module drom_arbiter
  import drom_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               a_req,
  input  logic [ADDR_W-1:0]  a_addr,
  input  logic [BURST_W-1:0] a_len,
  output logic               a_gnt,
  output logic               a_rvalid,
  output logic               a_rlast,
  output logic [DATA_W-1:0]  a_rdata,
  input  logic               b_req,
  input  logic [ADDR_W-1:0]  b_addr,
  input  logic [BURST_W-1:0] b_len,
  output logic               b_gnt,
  output logic               b_rvalid,
  output logic               b_rlast,
  output logic [DATA_W-1:0]  b_rdata,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [DATA_W-1:0]  rom_q
);

  localparam logic [BURST_W-1:0] LAST_CNT = BURST_W'(1);

  state_t              state_q, state_d;
  logic [BURST_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   last_addr_q;
  port_t               own_q, own_d;
  slot_t               slot_q, slot_d;
  logic [DATA_W-1:0]   a_hold_q, b_hold_q;

  logic                any_req;
  port_t               winner;
  logic [ADDR_W-1:0]   win_addr;
  logic [BURST_W-1:0]  win_len;

`ifdef DROM_ARB_RR_EN
  port_t ptr_q;

  drom_arb_pick u_pick (
    .a_req   (a_req),
    .b_req   (b_req),
    .ptr     (ptr_q),
    .any_req (any_req),
    .winner  (winner)
  );

  // Pointer moves away from whichever port just completed, so the other port wins the next tie.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                      ptr_q <= PORT_A;
    else if (slot_d.valid && slot_d.last) ptr_q <= other_port(slot_d.port);
  end
`else
  drom_arb_pick u_pick (
    .a_req   (a_req),
    .b_req   (b_req),
    .any_req (any_req),
    .winner  (winner)
  );
`endif

  assign win_addr = (winner == PORT_B) ? b_addr : a_addr;
  assign win_len  = (winner == PORT_B) ? b_len  : a_len;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    own_d       = own_q;
    slot_d      = '{valid: 1'b0, port: PORT_A, last: 1'b0};
    rom_address = last_addr_q;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;

    case (state_q)
      IDLE: begin
        // resetn gates the combinational grant so gnt reads 0 while reset is held.
        if (any_req && resetn) begin
          a_gnt       = (winner == PORT_A);
          b_gnt       = (winner == PORT_B);
          rom_address = win_addr;
          own_d       = winner;
          slot_d      = '{valid: 1'b1, port: winner, last: (win_len == '0)};
          if (win_len != '0) begin
            cnt_d   = win_len;
            addr_d  = win_addr + 1'b1;
            state_d = BURST;
          end
        end
      end
      BURST: begin
        rom_address = addr_q;
        addr_d      = addr_q + 1'b1;
        cnt_d       = cnt_q - 1'b1;
        slot_d      = '{valid: 1'b1, port: own_q, last: (cnt_q == LAST_CNT)};
        if (cnt_q == LAST_CNT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      own_q       <= PORT_A;
      slot_q      <= '{valid: 1'b0, port: PORT_A, last: 1'b0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      last_addr_q <= rom_address;
      own_q       <= own_d;
      slot_q      <= slot_d;
    end
  end

  assign a_rvalid = slot_q.valid && (slot_q.port == PORT_A);
  assign b_rvalid = slot_q.valid && (slot_q.port == PORT_B);
  assign a_rlast  = a_rvalid && slot_q.last;
  assign b_rlast  = b_rvalid && slot_q.last;
  assign a_rdata  = a_rvalid ? rom_q : a_hold_q;
  assign b_rdata  = b_rvalid ? rom_q : b_hold_q;

  // NOTE: hold registers are reset (unlike a bulk data array) because rdata must read 0 out of reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      if (a_rvalid) a_hold_q <= rom_q;
      if (b_rvalid) b_hold_q <= rom_q;
    end
  end

endmodule

// File: tb/tb_drom_arbiter.sv
// Directed self-checking bench for drom_arbiter with a registered-address DROM model.
// Expectations for the tie test follow DROM_ARB_RR_EN when it is defined.
module tb_drom_arbiter;
  import drom_pkg::*;

  logic               clock = 1'b0;
  logic               resetn;
  logic               a_req, b_req;
  logic [ADDR_W-1:0]  a_addr, b_addr;
  logic [BURST_W-1:0] a_len, b_len;
  logic               a_gnt, a_rvalid, a_rlast;
  logic               b_gnt, b_rvalid, b_rlast;
  logic [DATA_W-1:0]  a_rdata, b_rdata;
  logic [ADDR_W-1:0]  rom_address;
  logic [DATA_W-1:0]  rom_q;

  int checks = 0;
  int errors = 0;

  drom_arbiter dut (
    .clock       (clock),
    .resetn      (resetn),
    .a_req       (a_req),
    .a_addr      (a_addr),
    .a_len       (a_len),
    .a_gnt       (a_gnt),
    .a_rvalid    (a_rvalid),
    .a_rlast     (a_rlast),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_addr      (b_addr),
    .b_len       (b_len),
    .b_gnt       (b_gnt),
    .b_rvalid    (b_rvalid),
    .b_rlast     (b_rlast),
    .b_rdata     (b_rdata),
    .rom_address (rom_address),
    .rom_q       (rom_q)
  );

  always #5 clock = ~clock;

  // ROM contents: distinct word per address.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return {a ^ 7'h55, 2'b10, ~a};
  endfunction

  // DROM registers the address at the edge; q is valid the following cycle.
  always @(posedge clock) rom_q <= rom_word(rom_address);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic mid;
    @(negedge clock);
  endtask

  // Checks all A-side and B-side strobes and rom_address at mid-cycle.
  task automatic expect_cycle(input string tag,
                              input logic eag, input logic ebg,
                              input logic [ADDR_W-1:0] erom,
                              input logic eav, input logic eal,
                              input logic ebv, input logic ebl);
    mid();
    check({tag, " a_gnt"},    32'(a_gnt),       32'(eag));
    check({tag, " b_gnt"},    32'(b_gnt),       32'(ebg));
    check({tag, " rom_addr"}, 32'(rom_address), 32'(erom));
    check({tag, " a_rvalid"}, 32'(a_rvalid),    32'(eav));
    check({tag, " a_rlast"},  32'(a_rlast),     32'(eal));
    check({tag, " b_rvalid"}, 32'(b_rvalid),    32'(ebv));
    check({tag, " b_rlast"},  32'(b_rlast),     32'(ebl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] seq [5];
    resetn = 1'b0;
    a_req = 1'b0; a_addr = '0; a_len = '0;
    b_req = 1'b0; b_addr = '0; b_len = '0;
    repeat (2) next_cycle();

    // Reset state
    expect_cycle("rst", 0, 0, 7'd0, 0, 0, 0, 0);
    check("rst a_rdata", 32'(a_rdata), 32'd0);
    check("rst b_rdata", 32'(b_rdata), 32'd0);
    resetn = 1'b1;
    next_cycle();

    // Single beat on A at address 5
    a_req = 1'b1; a_addr = 7'd5; a_len = 2'd0;
    expect_cycle("t1c0", 1, 0, 7'd5, 0, 0, 0, 0);
    next_cycle(); a_req = 1'b0;
    expect_cycle("t1c1", 0, 0, 7'd5, 1, 1, 0, 0);
    check("t1c1 a_rdata", 32'(a_rdata), 32'(rom_word(7'd5)));
    next_cycle();
    expect_cycle("t1c2", 0, 0, 7'd5, 0, 0, 0, 0);
    next_cycle();
    mid();
    check("t1c3 a_rdata hold", 32'(a_rdata), 32'(rom_word(7'd5)));
    next_cycle();

    // Four-beat burst on B wrapping 126,127,0,1
    seq[0] = 7'd126; seq[1] = 7'd127; seq[2] = 7'd0; seq[3] = 7'd1; seq[4] = 7'd1;
    b_req = 1'b1; b_addr = 7'd126; b_len = 2'd3;
    for (int k = 0; k < 5; k++) begin
      expect_cycle($sformatf("t2c%0d", k), 0, (k == 0), seq[k], 0, 0, (k >= 1), (k == 4));
      if (k >= 1) check($sformatf("t2c%0d b_rdata", k), 32'(b_rdata), 32'(rom_word(seq[k-1])));
      next_cycle();
      b_req = 1'b0;
    end
    mid();
    check("t2 b_rdata hold", 32'(b_rdata), 32'(rom_word(7'd1)));
    check("t2 a_rdata untouched", 32'(a_rdata), 32'(rom_word(7'd5)));
    next_cycle();

    // Simultaneous requests, both len=1; A then keeps requesting
    a_req = 1'b1; a_addr = 7'd20; a_len = 2'd1;
    b_req = 1'b1; b_addr = 7'd60; b_len = 2'd1;
    expect_cycle("t3c0", 1, 0, 7'd20, 0, 0, 0, 0);
    next_cycle(); a_addr = 7'd30; a_len = 2'd0;
    expect_cycle("t3c1", 0, 0, 7'd21, 1, 0, 0, 0);
    check("t3c1 a_rdata", 32'(a_rdata), 32'(rom_word(7'd20)));
    next_cycle();
`ifdef DROM_ARB_RR_EN
    expect_cycle("t3c2", 0, 1, 7'd60, 1, 1, 0, 0);
    check("t3c2 a_rdata", 32'(a_rdata), 32'(rom_word(7'd21)));
    next_cycle(); b_req = 1'b0;
    expect_cycle("t3c3", 0, 0, 7'd61, 0, 0, 1, 0);
    check("t3c3 b_rdata", 32'(b_rdata), 32'(rom_word(7'd60)));
    next_cycle();
    expect_cycle("t3c4", 1, 0, 7'd30, 0, 0, 1, 1);
    check("t3c4 b_rdata", 32'(b_rdata), 32'(rom_word(7'd61)));
    next_cycle(); a_req = 1'b0;
    expect_cycle("t3c5", 0, 0, 7'd30, 1, 1, 0, 0);
    check("t3c5 a_rdata", 32'(a_rdata), 32'(rom_word(7'd30)));
    next_cycle();
`else
    expect_cycle("t3c2", 1, 0, 7'd30, 1, 1, 0, 0);
    check("t3c2 a_rdata", 32'(a_rdata), 32'(rom_word(7'd21)));
    next_cycle();
    expect_cycle("t3c3", 1, 0, 7'd30, 1, 1, 0, 0);
    next_cycle(); a_req = 1'b0;
    expect_cycle("t3c4", 0, 1, 7'd60, 1, 1, 0, 0);
    next_cycle(); b_req = 1'b0;
    expect_cycle("t3c5", 0, 0, 7'd61, 0, 0, 1, 0);
    check("t3c5 b_rdata", 32'(b_rdata), 32'(rom_word(7'd60)));
    next_cycle();
    expect_cycle("t3c6", 0, 0, 7'd61, 0, 0, 1, 1);
    check("t3c6 b_rdata", 32'(b_rdata), 32'(rom_word(7'd61)));
    next_cycle();
`endif

    // A arrives during a B burst and waits for B's final beat
    b_req = 1'b1; b_addr = 7'd10; b_len = 2'd3;
    expect_cycle("t4c0", 0, 1, 7'd10, 0, 0, 0, 0);
    next_cycle(); b_req = 1'b0;
    a_req = 1'b1; a_addr = 7'd40; a_len = 2'd0;
    for (int k = 1; k < 4; k++) begin
      expect_cycle($sformatf("t4c%0d", k), 0, 0, 7'(10 + k), 0, 0, 1, 0);
      check($sformatf("t4c%0d b_rdata", k), 32'(b_rdata), 32'(rom_word(7'(9 + k))));
      next_cycle();
    end
    expect_cycle("t4c4", 1, 0, 7'd40, 0, 0, 1, 1);
    check("t4c4 b_rdata", 32'(b_rdata), 32'(rom_word(7'd13)));
    next_cycle(); a_req = 1'b0;
    expect_cycle("t4c5", 0, 0, 7'd40, 1, 1, 0, 0);
    check("t4c5 a_rdata", 32'(a_rdata), 32'(rom_word(7'd40)));
    next_cycle();

    // Reset asserted on the second beat of a len=3 burst
    a_req = 1'b1; a_addr = 7'd100; a_len = 2'd3;
    expect_cycle("t5c0", 1, 0, 7'd100, 0, 0, 0, 0);
    next_cycle(); a_req = 1'b0;
    expect_cycle("t5c1", 0, 0, 7'd101, 1, 0, 0, 0);
    resetn = 1'b0;
    #1;
    check("t5 rst a_rvalid", 32'(a_rvalid), 32'd0);
    check("t5 rst a_rdata", 32'(a_rdata), 32'd0);
    check("t5 rst b_rdata", 32'(b_rdata), 32'd0);
    check("t5 rst rom_addr", 32'(rom_address), 32'd0);
    next_cycle();
    next_cycle();
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      expect_cycle($sformatf("t5 post%0d", k), 0, 0, 7'd0, 0, 0, 0, 0);
      next_cycle();
    end
    b_req = 1'b1; b_addr = 7'd7; b_len = 2'd0;
    expect_cycle("t5 new c0", 0, 1, 7'd7, 0, 0, 0, 0);
    next_cycle(); b_req = 1'b0;
    expect_cycle("t5 new c1", 0, 0, 7'd7, 0, 0, 1, 1);
    check("t5 new b_rdata", 32'(b_rdata), 32'(rom_word(7'd7)));
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
